// File: rtl/lpif_tx_stb_mrk_sched.sv
// rtl/lpif_tx_stb_mrk_sched.sv - TX link bring-up sequencer generating strobe/marker userbits and downstream pop
module lpif_tx_stb_mrk_sched #(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned STB_INTERVAL  = 24,
  parameter int unsigned STAT_W        = 16
) (
  input  logic              clk_wr,
  input  logic              rst_wr_n,
  input  logic              tx_online,
  input  logic [1:0]        rate_sel,
  output logic              tx_stb_userbit,
  output logic              tx_mrk_userbit,
  output logic              tx_downstream_pop,
  output logic [1:0]        sched_state,
  output logic [STAT_W-1:0] stb_sent_cnt
);

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2,
    ST_DRAIN  = 2'd3
  } state_e;

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] GRP_LAST    = 8'(STB_INTERVAL - 1);

  state_e            state_q, state_d;
  logic [7:0]        settle_cnt_q, settle_cnt_d;
  logic [1:0]        beat_cnt_q, beat_cnt_d;
  logic [2:0]        grp_size_q, grp_size_d;
  logic [7:0]        grp_cnt_q, grp_cnt_d;
  logic [STAT_W-1:0] stb_cnt_q, stb_cnt_d;

  logic active;
  logic beat_last;
  logic stb_beat;

  assign active    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign beat_last = ({1'b0, beat_cnt_q} == (grp_size_q - 3'd1));
  assign stb_beat  = active && (beat_cnt_q == 2'd0) && (grp_cnt_q == 8'd0);

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    beat_cnt_d   = beat_cnt_q;
    grp_size_d   = grp_size_q;
    grp_cnt_d    = grp_cnt_q;
    stb_cnt_d    = stb_cnt_q;

    if (active) begin
      if (beat_last) begin
        beat_cnt_d = 2'd0;
        grp_cnt_d  = (grp_cnt_q == GRP_LAST) ? 8'd0 : grp_cnt_q + 8'd1;
      end else begin
        beat_cnt_d = beat_cnt_q + 2'd1;
      end
    end

    if (stb_beat && (stb_cnt_q != {STAT_W{1'b1}})) begin
      stb_cnt_d = stb_cnt_q + 1'b1;
    end

    case (state_q)
      ST_OFF: begin
        // rate_sel 3 folds onto quarter rate
        case (rate_sel)
          2'd0:    grp_size_d = 3'd1;
          2'd1:    grp_size_d = 3'd2;
          default: grp_size_d = 3'd4;
        endcase
        if (tx_online) begin
          state_d      = ST_SETTLE;
          settle_cnt_d = SETTLE_LOAD;
          beat_cnt_d   = 2'd0;
          grp_cnt_d    = 8'd0;
        end
      end
      ST_SETTLE: begin
        if (!tx_online) begin
          state_d = ST_OFF;
        end else if (settle_cnt_q == 8'd0) begin
          state_d = ST_RUN;
        end else begin
          settle_cnt_d = settle_cnt_q - 8'd1;
        end
      end
      ST_RUN: begin
        if (!tx_online) begin
          state_d = beat_last ? ST_OFF : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // finish the marker group so no partial group reaches the concat block
        if (beat_last) begin
          state_d = ST_OFF;
        end
      end
      default: state_d = ST_OFF;
    endcase
  end

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      state_q      <= ST_OFF;
      settle_cnt_q <= 8'd0;
      beat_cnt_q   <= 2'd0;
      grp_size_q   <= 3'd1;
      grp_cnt_q    <= 8'd0;
      stb_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      beat_cnt_q   <= beat_cnt_d;
      grp_size_q   <= grp_size_d;
      grp_cnt_q    <= grp_cnt_d;
      stb_cnt_q    <= stb_cnt_d;
    end
  end

  assign tx_downstream_pop = active;
  assign tx_mrk_userbit    = active && beat_last;
  assign tx_stb_userbit    = stb_beat;
  assign sched_state       = state_q;
  assign stb_sent_cnt      = stb_cnt_q;

endmodule

// File: tb/tb_lpif_tx_stb_mrk_sched.sv
// tb/tb_lpif_tx_stb_mrk_sched.sv - self-checking bench for lpif_tx_stb_mrk_sched
module tb_lpif_tx_stb_mrk_sched;

  localparam int S    = 4;
  localparam int I    = 3;
  localparam int W    = 4;
  localparam int SMAX = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         online = 1'b0;
  logic [1:0]   rate_sel = 2'd0;
  logic         stb, mrk, pop;
  logic [1:0]   st;
  logic [W-1:0] cnt;

  int n_chk = 0;
  int n_err = 0;

  lpif_tx_stb_mrk_sched #(
    .SETTLE_CYCLES(S),
    .STB_INTERVAL (I),
    .STAT_W       (W)
  ) dut (
    .clk_wr           (clk),
    .rst_wr_n         (rst_n),
    .tx_online        (online),
    .rate_sel         (rate_sel),
    .tx_stb_userbit   (stb),
    .tx_mrk_userbit   (mrk),
    .tx_downstream_pop(pop),
    .sched_state      (st),
    .stb_sent_cnt     (cnt)
  );

  always #5 clk = ~clk;

  // Model: phase, cycles spent settling, index of the current active beat since run start
  int m_st, m_settle, m_idx, m_g, m_stb, m_nxt;
  bit m_act, m_mk, m_sb;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st = 0; m_settle = 0; m_idx = 0; m_g = 1; m_stb = 0;
    end else begin
      m_act = (m_st >= 2);
      m_mk  = m_act && (m_idx % m_g == m_g - 1);
      m_sb  = m_act && (m_idx % (m_g * I) == 0);
      if (m_sb && m_stb < SMAX) m_stb++;
      m_nxt = m_st;
      case (m_st)
        0: begin
          m_g = (rate_sel == 2'd0) ? 1 : (rate_sel == 2'd1) ? 2 : 4;
          if (online) begin m_nxt = 1; m_settle = 0; m_idx = 0; end
        end
        1: begin
          if (!online) m_nxt = 0;
          else if (m_settle == S - 1) m_nxt = 2;
          else m_settle++;
        end
        2: if (!online) m_nxt = m_mk ? 0 : 3;
        default: if (m_mk) m_nxt = 0;
      endcase
      if (m_act) m_idx++;
      m_st = m_nxt;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    bit a;
    a = (m_st >= 2);
    chk("state", 32'(st), 32'(m_st));
    chk("pop", 32'(pop), 32'(a));
    chk("mrk", 32'(mrk), 32'(a && (m_idx % m_g == m_g - 1)));
    chk("stb", 32'(stb), 32'(a && (m_idx % (m_g * I) == 0)));
    chk("stb_cnt", 32'(cnt), 32'(m_stb));
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      compare_all();
    end
  endtask

  initial begin
    step(3);
    chk("rst_state", 32'(st), 0);
    chk("rst_pop", 32'(pop), 0);
    chk("rst_cnt", 32'(cnt), 0);
    rst_n = 1'b1;
    step(2);

    // full rate bring-up and strobe spacing
    online = 1'b1;
    step(4);
    chk("fr_settle_state", 32'(st), 1);
    chk("fr_settle_pop", 32'(pop), 0);
    step();
    chk("fr_first_pop", 32'(pop), 1);
    chk("fr_first_stb", 32'(stb), 1);
    chk("fr_first_mrk", 32'(mrk), 1);
    step();
    chk("fr_idx1_stb", 32'(stb), 0);
    chk("fr_idx1_mrk", 32'(mrk), 1);
    step(2);
    chk("fr_idx3_stb", 32'(stb), 1);
    step(3);
    chk("fr_idx6_stb", 32'(stb), 1);
    step();
    chk("fr_cnt3", 32'(cnt), 3);
    online = 1'b0;
    step();
    chk("fr_drop_off", 32'(st), 0);
    chk("fr_drop_pop", 32'(pop), 0);

    // quarter rate, rate change mid-run, drop at beat 1
    rate_sel = 2'd2;
    online   = 1'b1;
    step(5);
    chk("qr_k0_stb", 32'(stb), 1);
    chk("qr_k0_mrk", 32'(mrk), 0);
    for (int k = 1; k <= 13; k++) begin
      step();
      chk("qr_mrk_pat", 32'(mrk), 32'(k % 4 == 3));
      chk("qr_stb_pat", 32'(stb), 32'(k % 12 == 0));
      if (k == 6) rate_sel = 2'd0;
    end
    online = 1'b0;
    step();
    chk("qr_drain_state", 32'(st), 3);
    chk("qr_drain_b2_mrk", 32'(mrk), 0);
    chk("qr_drain_b2_pop", 32'(pop), 1);
    step();
    chk("qr_drain_b3_mrk", 32'(mrk), 1);
    chk("qr_drain_b3_pop", 32'(pop), 1);
    step();
    chk("qr_end_state", 32'(st), 0);
    chk("qr_end_pop", 32'(pop), 0);
    chk("qr_cnt", 32'(cnt), 5);

    // async reset mid-run, then full settle on restart
    rate_sel = 2'd0;
    online   = 1'b1;
    step(7);
    chk("pre_rst_pop", 32'(pop), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pop", 32'(pop), 0);
    chk("arst_state", 32'(st), 0);
    chk("arst_cnt", 32'(cnt), 0);
    chk("arst_mrk", 32'(mrk), 0);
    compare_all();
    step();
    rst_n = 1'b1;
    step(4);
    chk("restart_settle_pop", 32'(pop), 0);
    step();
    chk("restart_pop", 32'(pop), 1);

    // saturation of the strobe counter
    step(50);
    chk("sat_cnt", 32'(cnt), SMAX);

    // drop during SETTLE: never pops
    online = 1'b0;
    step();
    online = 1'b1;
    step(3);
    chk("settle_drop_pre", 32'(st), 1);
    online = 1'b0;
    step();
    chk("settle_drop_off", 32'(st), 0);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("settle_drop_nopop", 32'(pop), 0);
    end

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step();
      if ($urandom_range(0, 15) == 0) online = ~online;
      rate_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 399) == 0) begin
        #2 rst_n = 1'b0;
        #1 compare_all();
        step();
        rst_n = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
